// File: rtl/serdes_pkg.sv
// Shared constants and state encoding for the 10-bit serializer.
// Codewords are packed {j,h,g,f,i,e,d,c,b,a}; bit 0 is sent first.
package serdes_pkg;

    localparam int CW_WIDTH = 10;
    localparam logic [CW_WIDTH-1:0] K28_5_RDN = 10'h17C;
    localparam logic [CW_WIDTH-1:0] K28_5_RDP = 10'h283;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/contador_bits.sv
// Mod-10 bit-position counter. Resets to 9 so the first enabled edge
// after reset is a word load; tc flags the last bit slot of a word.
module contador_bits (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enb,
    output logic [3:0] count,
    output logic       tc
);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= 4'd9;
        end else if (enb) begin
            count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
        end
    end

    assign tc = (count == 4'd9);

endmodule

// File: rtl/serializador_10b.sv
// Parallel-to-serial stage after the 8b/10b encoder: sends SYNC_WORDS commas
// after reset, then one upstream word per 10 enabled clocks, comma-filling gaps.
module serializador_10b
    import serdes_pkg::*;
#(
    parameter int                  SYNC_WORDS = 4,
    parameter logic [CW_WIDTH-1:0] COMMA      = K28_5_RDN
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enb,
    input  logic [CW_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_serial,
    output logic                word_start,
    output logic                idle,
    output logic                underrun,
    output logic                synced
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_WORDS - 1);

    state_t              state;
    logic [CW_WIDTH-1:0] shift_reg;
    logic [3:0]          bit_cnt;
    logic                tc;
    logic                load;
    logic [7:0]          sync_cnt;
    logic                loaded;

    contador_bits u_contador_bits (
        .clk     (clk),
        .reset_L (reset_L),
        .enb     (enb),
        .count   (bit_cnt),
        .tc      (tc)
    );

    assign load = enb & tc;

    // Handshake: a word is taken on the rising edge where in_valid and in_ready
    // are both high; in_ready is only offered in RUN on an enabled load edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            shift_reg <= '0;
            state     <= SYNC;
            sync_cnt  <= 8'd0;
            loaded    <= 1'b0;
            underrun  <= 1'b0;
            idle      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load) begin
                loaded <= 1'b1;
                if (state == SYNC) begin
                    shift_reg <= COMMA;
                    idle      <= 1'b1;
                    if (sync_cnt != 8'hFF) begin
                        sync_cnt <= sync_cnt + 8'd1;
                    end
                    if (sync_cnt == SYNC_LAST) begin
                        state <= RUN;
                    end
                end else if (in_valid) begin
                    shift_reg <= in_data;
                    idle      <= 1'b0;
                end else begin
                    shift_reg <= COMMA;
                    idle      <= 1'b1;
                    underrun  <= 1'b1;
                end
            end else if (enb) begin
                shift_reg <= {1'b0, shift_reg[CW_WIDTH-1:1]};
            end
        end
    end

    assign out_serial = shift_reg[0];
    assign word_start = loaded & (bit_cnt == 4'd0);
    assign in_ready   = (state == RUN) & load;
    assign synced     = (state == RUN);

endmodule

// File: tb/tb_serializador_10b.sv
// Directed bench for serializador_10b: an edge-count model checked every cycle
// plus hand-computed bit patterns for sync, data, underrun, stall and reset.
module tb_serializador_10b;

    localparam int         SW    = 4;
    localparam logic [9:0] COMMA = 10'h17C;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enb = 1'b0;
    logic [9:0] in_data = 10'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, out_serial, word_start, idle, underrun, synced;

    int n_cmp = 0;
    int n_bad = 0;

    logic exp_q[$];

    serializador_10b #(.SYNC_WORDS(SW), .COMMA(COMMA)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enb        (enb),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_serial (out_serial),
        .word_start (word_start),
        .idle       (idle),
        .underrun   (underrun),
        .synced     (synced)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: words are loaded on every 10th enabled edge since reset
    int         m_n = 0;
    int         m_loads = 0;
    logic [9:0] m_word = 10'd0;
    logic       m_idle = 1'b0;
    logic       m_und = 1'b0;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_n     = 0;
            m_loads = 0;
            m_word  = 10'd0;
            m_idle  = 1'b0;
            m_und   = 1'b0;
        end else begin
            m_und = 1'b0;
            if (enb) begin
                if (m_n % 10 == 0) begin
                    if (m_loads < SW) begin
                        m_word = COMMA;
                        m_idle = 1'b1;
                    end else if (in_valid) begin
                        m_word = in_data;
                        m_idle = 1'b0;
                    end else begin
                        m_word = COMMA;
                        m_idle = 1'b1;
                        m_und  = 1'b1;
                    end
                    m_loads++;
                end
                m_n++;
            end
        end
    end

    // compare process: every cycle, mid-period
    int   c_pos;
    logic c_bit;
    always @(negedge clk) begin
        c_pos = (m_n == 0) ? 0 : (m_n - 1) % 10;
        c_bit = (m_n == 0) ? 1'b0 : m_word[c_pos];
        chk("m_out_serial", {31'd0, out_serial}, {31'd0, c_bit});
        chk("m_word_start", {31'd0, word_start}, {31'd0, (m_n > 0) && (c_pos == 0)});
        chk("m_idle",       {31'd0, idle},       {31'd0, m_idle});
        chk("m_underrun",   {31'd0, underrun},   {31'd0, m_und});
        chk("m_synced",     {31'd0, synced},     {31'd0, m_loads >= SW});
        chk("m_in_ready",   {31'd0, in_ready},
            {31'd0, enb && (m_n % 10 == 0) && (m_loads >= SW)});
    end

    // driver: present a word before a load edge, then check its 10 bits literally
    task automatic send_word(input string name, input logic [9:0] w, input logic valid,
                             input logic [9:0] exp_w, input logic exp_idle,
                             input logic exp_ready, input int exp_und);
        int und_cnt;
        logic b;
        #1;
        in_valid = valid;
        in_data  = w;
        chk({name, "_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_w[i]);
        @(posedge clk); #1;
        und_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b = exp_q.pop_front();
            chk({name, "_bit"},   {31'd0, out_serial}, {31'd0, b});
            chk({name, "_start"}, {31'd0, word_start}, {31'd0, i == 0});
            chk({name, "_idle"},  {31'd0, idle},       {31'd0, exp_idle});
            if (underrun) und_cnt++;
        end
        chk({name, "_und_cycles"}, und_cnt, exp_und);
    endtask

    logic [9:0] stall_w;
    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_serial", {31'd0, out_serial}, 0);
        chk("rst_word_start", {31'd0, word_start}, 0);
        chk("rst_in_ready",   {31'd0, in_ready},   0);
        chk("rst_synced",     {31'd0, synced},     0);
        chk("rst_idle",       {31'd0, idle},       0);
        chk("rst_underrun",   {31'd0, underrun},   0);
        reset_L = 1'b1;
        enb     = 1'b1;

        // sync commas: 0,0,1,1,1,1,1,0,1,0 four times
        for (int k = 0; k < SW; k++) begin
            send_word("sync", 10'h000, 1'b0, 10'h17C, 1'b1, 1'b0, 0);
            chk("sync_synced", {31'd0, synced}, {31'd0, k == SW - 1});
        end

        // first data word after sync
        send_word("d2aa", 10'h2AA, 1'b1, 10'h2AA, 1'b0, 1'b1, 0);
        // back-to-back
        send_word("d3ff", 10'h3FF, 1'b1, 10'h3FF, 1'b0, 1'b1, 0);
        send_word("d000", 10'h000, 1'b1, 10'h000, 1'b0, 1'b1, 0);
        // underrun then recovery
        send_word("gap",  10'h0F0, 1'b0, 10'h17C, 1'b1, 1'b1, 1);
        send_word("d0c3", 10'h0C3, 1'b1, 10'h0C3, 1'b0, 1'b1, 0);

        // stall for 7 cycles after bit 3 of 10'h155
        stall_w  = 10'h155;
        #1;
        in_valid = 1'b1;
        in_data  = stall_w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            chk("stall_pre_bit", {31'd0, out_serial}, {31'd0, stall_w[i]});
        end
        enb = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("stall_hold",  {31'd0, out_serial}, {31'd0, stall_w[3]});
            chk("stall_ready", {31'd0, in_ready},   0);
        end
        enb = 1'b1;
        for (int i = 4; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_post_bit", {31'd0, out_serial}, {31'd0, stall_w[i]});
        end
        // 3 + 7 + 6 edges elapsed: the 17th edge is the next load
        chk("stall_word_time", {31'd0, in_ready}, 1);

        // reset for one cycle at bit 5 of 10'h1F0
        in_valid = 1'b1;
        in_data  = 10'h1F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("mid_bit5", {31'd0, out_serial}, 1);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_out",    {31'd0, out_serial}, 0);
        chk("mid_rst_synced", {31'd0, synced},     0);
        chk("mid_rst_ready",  {31'd0, in_ready},   0);
        @(posedge clk); #1;
        reset_L = 1'b1;
        for (int k = 0; k < SW; k++) begin
            send_word("resync", 10'h3FF, 1'b1, 10'h17C, 1'b1, 1'b0, 0);
            chk("resync_synced", {31'd0, synced}, {31'd0, k == SW - 1});
        end
        send_word("d1a5", 10'h1A5, 1'b1, 10'h1A5, 1'b0, 1'b1, 0);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
